// File: rtl/dot_tracker_pkg.sv
// Shared types and defaults for the dot tracker.
package dot_tracker_pkg;

  localparam int NUM_DOTS_DEF     = 10;
  localparam int CLEAR_FRAMES_DEF = 60;
  localparam int SCORE_W          = 4;
  localparam int LEVEL_W          = 4;

  typedef enum logic [1:0] {
    ST_PLAY   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_REFILL = 2'd2
  } dot_state_e;

endpackage

// File: rtl/dot_popcount.sv
// Combinational population count of a dot mask.
module dot_popcount #(
  parameter  int W  = 10,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  bits,
  output logic [CW-1:0] count
);

  // Ripple sum of the set bits; W is small so a plain adder chain is enough.
  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) count = count + CW'(bits[i]);
  end

endmodule

// File: rtl/dot_tracker.sv
// Dot tracker: collects per-pixel eat requests during a frame and commits them
// on frame_start; runs the level-clear / refill sequence once every dot is gone.
module dot_tracker
  import dot_tracker_pkg::*;
#(
  parameter int NUM_DOTS     = NUM_DOTS_DEF,
  parameter int CLEAR_FRAMES = CLEAR_FRAMES_DEF
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                frame_start,
  input  logic                restart,
  input  logic [NUM_DOTS-1:0] kill_10,
  output logic [NUM_DOTS-1:0] alive_10,
  output logic [SCORE_W-1:0]  score,
  output logic [LEVEL_W-1:0]  level,
  output logic                eat_pulse,
  output logic                level_clear
);

  localparam int CNT_W = $clog2(NUM_DOTS + 1);
  localparam int FC_W  = $clog2(CLEAR_FRAMES + 1);

  dot_state_e          state, state_nxt;
  logic [NUM_DOTS-1:0] pending;
  logic [NUM_DOTS-1:0] newly;
  logic                commit;
  logic [FC_W-1:0]     frame_cnt;
  logic [CNT_W-1:0]    eaten;
  logic [SCORE_W:0]    score_sum;
  logic [SCORE_W-1:0]  score_sat;
  logic                sync_rst;

  // restart behaves exactly like Reset and overrides everything else
  assign sync_rst = Reset | restart;

  dot_popcount #(.W(NUM_DOTS)) u_popcount (
    .bits  (newly),
    .count (eaten)
  );

  // Saturating score update; one extra bit catches the overflow
  always_comb begin
    score_sum = {1'b0, score} + (SCORE_W + 1)'(eaten);
    score_sat = score_sum[SCORE_W-1:0];
    if (score_sum > (SCORE_W + 1)'(NUM_DOTS)) score_sat = SCORE_W'(NUM_DOTS);
  end

  // State register
  always_ff @(posedge Clk) begin
    if (sync_rst) state <= ST_PLAY;
    else          state <= state_nxt;
  end

  // Next-state and commit decode; same-cycle kills join the commit
  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    newly     = '0;
    case (state)
      ST_PLAY: begin
        if (frame_start) begin
          commit = 1'b1;
          newly  = (pending | kill_10) & alive_10;
          if ((alive_10 & ~newly) == '0) state_nxt = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (frame_start && frame_cnt == FC_W'(CLEAR_FRAMES - 1)) state_nxt = ST_REFILL;
      end
      ST_REFILL: state_nxt = ST_PLAY;
      default:   state_nxt = ST_PLAY;
    endcase
  end

  // Dot mask, pending kills, score, level, frame counter and eat pulse
  always_ff @(posedge Clk) begin
    if (sync_rst) begin
      alive_10  <= '1;
      pending   <= '0;
      score     <= '0;
      level     <= '0;
      eat_pulse <= 1'b0;
      frame_cnt <= '0;
    end else begin
      eat_pulse <= 1'b0;
      case (state)
        ST_PLAY: begin
          if (commit) begin
            alive_10  <= alive_10 & ~newly;
            pending   <= '0;
            score     <= score_sat;
            eat_pulse <= |newly;
            if (state_nxt == ST_CLEAR) frame_cnt <= '0;
          end else begin
            // Only live dots are remembered, so repeats and dead dots vanish
            pending <= pending | (kill_10 & alive_10);
          end
        end
        ST_CLEAR: begin
          pending <= '0;
          if (frame_start) frame_cnt <= frame_cnt + FC_W'(1);
        end
        ST_REFILL: begin
          alive_10 <= '1;
          score    <= '0;
          level    <= level + LEVEL_W'(1);
          pending  <= '0;
        end
        default: pending <= '0;
      endcase
    end
  end

  assign level_clear = (state == ST_CLEAR);

endmodule

// File: doc/dot_tracker.md
DOT_TRACKER -- requirements
Module: dot_tracker

Interface
REQ-001 Parameter NUM_DOTS, default 10, number of collectible dots; bit i of every dot mask is dot i.
REQ-002 Parameter CLEAR_FRAMES, default 60, number of frames the level-clear state is held.
REQ-003 Clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 frame_start  input  1  one-Clk pulse per video frame; the commit strobe.
REQ-006 restart  input  1  synchronous game-restart request; same effect as Reset.
REQ-007 kill_10  input  NUM_DOTS  per-pixel eat requests from the color mapper; may toggle every Clk.
REQ-008 alive_10  output  NUM_DOTS  registered mask of dots still on screen; fed back to the color mapper.
REQ-009 score  output  4  registered count of dots eaten in the current level, 0..NUM_DOTS.
REQ-010 level  output  4  registered count of completed levels, wraps 15->0.
REQ-011 eat_pulse  output  1  one-Clk pulse when a commit removes at least one dot.
REQ-012 level_clear  output  1  high throughout the CLEAR state.

Function
REQ-013 The block SHALL implement states PLAY, CLEAR and REFILL.
REQ-014 In PLAY, each Clk the block SHALL OR (kill_10 AND alive_10) into an internal pending mask.
REQ-015 On a PLAY cycle with frame_start=1, the block SHALL commit: newly = (pending OR kill_10) AND alive_10; alive_10 <= alive_10 AND NOT newly; pending <= 0.
REQ-016 A kill_10 bit asserted in the same cycle as frame_start SHALL be included in that commit, not deferred.
REQ-017 At commit, score SHALL increase by popcount(newly), saturating at NUM_DOTS.
REQ-018 eat_pulse SHALL be 1 for exactly the Clk following a commit with newly != 0, otherwise 0.
REQ-019 alive_10 and score SHALL change only at commits, REFILL, reset or restart; never mid-frame.
REQ-020 Repeated or held kill bits for the same dot within one frame SHALL be counted once.
REQ-021 Kill bits for dots already dead SHALL be ignored.
REQ-022 If a commit leaves alive_10 == 0, the next state SHALL be CLEAR and the frame counter SHALL be zeroed.
REQ-023 In CLEAR, kill_10 SHALL be ignored, pending held at 0 and level_clear = 1; each frame_start increments the frame counter.
REQ-024 On the frame_start that brings the counter to CLEAR_FRAMES, the next state SHALL be REFILL.
REQ-025 REFILL SHALL last exactly one Clk: alive_10 <= all ones, score <= 0, level <= level+1 (mod 16), pending <= 0, next state PLAY.
REQ-026 restart SHALL take priority over every other event in that cycle, including a commit or REFILL.
REQ-027 The frame counter SHALL be wide enough for CLEAR_FRAMES without wrap.

Reset
REQ-028 On Reset or restart the block SHALL set state PLAY, alive_10 all ones, pending 0, score 0, level 0, eat_pulse 0, level_clear 0, frame counter 0.
REQ-029 Reset asserted mid-frame SHALL discard the pending kills of that frame.

Structure
REQ-030 A shared package SHALL hold the state enum type, NUM_DOTS and CLEAR_FRAMES defaults, and the 4-bit score/level widths.
REQ-031 A combinational popcount sub-module, dot_popcount, SHALL compute popcount(newly); everything else stays in dot_tracker.

Verification
REQ-032 Reset, then kill_10=10'h004 for 3 cycles mid-frame, then frame_start -> alive_10=10'h3FB, score=1, eat_pulse high 1 Clk; no change before the commit.
REQ-033 kill_10=10'h003 in the frame_start cycle only -> included in that commit: alive_10=10'h3FC, score=2.
REQ-034 Kill dot 2 twice in two separate frames -> score=1 after both commits; second commit gives no eat_pulse.
REQ-035 Eat all 10 dots -> level_clear=1; 60 frame_starts later, one REFILL Clk, then alive_10=10'h3FF, score=0, level=1, PLAY; kills during CLEAR ignored.
REQ-036 restart asserted in the same cycle as a commit with kill_10=10'h3FF -> alive_10=10'h3FF, score=0, level=0, no eat_pulse, no CLEAR.
